// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-macro bus bundle for mem_port_arbiter
//
// Purpose: groups every non-clock signal of the arbiter so that one
// connection carries both requester channels and the macro port.
// Ports (as seen by the arbiter through modport slave):
//   protocol : p_req, p_we, p_addr[5:0], p_sel[2:0], p_wdata[15:0] in;
//              p_ack, p_err, p_rdata[15:0] out
//   sensor   : s_req, s_addr[5:0], s_sel[2:0], s_wdata[15:0] in;
//              s_ack, s_err out
//   control  : tx_enable in; busy out
//   macro    : mem_read_in[15:0] in; mem_data_out[15:0], mem_address[5:0],
//              mem_sel[2:0], PC_B, WE, SE out
// modport master is the mirror image, for whatever drives the requests.
interface mem_port_arbiter_if;
  logic        p_req;
  logic        p_we;
  logic [5:0]  p_addr;
  logic [2:0]  p_sel;
  logic [15:0] p_wdata;
  logic        p_ack;
  logic        p_err;
  logic [15:0] p_rdata;
  logic        s_req;
  logic [5:0]  s_addr;
  logic [2:0]  s_sel;
  logic [15:0] s_wdata;
  logic        s_ack;
  logic        s_err;
  logic        tx_enable;
  logic [15:0] mem_read_in;
  logic [15:0] mem_data_out;
  logic [5:0]  mem_address;
  logic [2:0]  mem_sel;
  logic        PC_B;
  logic        WE;
  logic        SE;
  logic        busy;

  modport slave (
    input  p_req, p_we, p_addr, p_sel, p_wdata,
    output p_ack, p_err, p_rdata,
    input  s_req, s_addr, s_sel, s_wdata,
    output s_ack, s_err,
    input  tx_enable, mem_read_in,
    output mem_data_out, mem_address, mem_sel, PC_B, WE, SE, busy
  );

  modport master (
    output p_req, p_we, p_addr, p_sel, p_wdata,
    input  p_ack, p_err, p_rdata,
    output s_req, s_addr, s_sel, s_wdata,
    input  s_ack, s_err,
    output tx_enable, mem_read_in,
    input  mem_data_out, mem_address, mem_sel, PC_B, WE, SE, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter and phase sequencer for the tag memory macro port
//
// Purpose: grants one of the protocol or sensor requests at a time and
// runs precharge -> sense/write -> done on the macro, with a starvation
// guard that forces a pending sensor write through after STARVE_LIMIT
// consecutive protocol wins.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requester channels + macro port)
module mem_port_arbiter #(
  parameter int PRE_CYC      = 2,
  parameter int SENSE_CYC    = 2,
  parameter int WRITE_CYC    = 4,
  parameter int MEM_WORDS    = 48,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] PRE_LAST   = 4'(PRE_CYC - 1);
  localparam logic [3:0] SENSE_LAST = 4'(SENSE_CYC - 1);
  localparam logic [3:0] WRITE_LAST = 4'(WRITE_CYC - 1);
  localparam logic [6:0] ADDR_LIM   = 7'(MEM_WORDS);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, PRECH, ACCESS, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  starve_cnt;
  logic        own_s;      // latched winner: 1 = sensor
  logic        we_l;       // latched access type
  logic        err_l;      // latched address reject
  logic [5:0]  addr_q;
  logic [2:0]  sel_q;
  logic [15:0] dout_q;
  logic [15:0] rdata_q;

  logic        s_elig, grant_any, grant_s, addr_bad, acc_end;
  logic [5:0]  win_addr;
  logic [3:0]  acc_last;

  // Sensor needs a quiet RF front end; the protocol always wins a tie
  // until the starve counter saturates.
  assign s_elig    = bus.s_req && !bus.tx_enable;
  assign grant_any = bus.p_req || s_elig;
  assign grant_s   = s_elig && (!bus.p_req || starve_cnt == STARVE_MAX);
  assign win_addr  = grant_s ? bus.s_addr : bus.p_addr;
  assign addr_bad  = {1'b0, win_addr} >= ADDR_LIM;
  assign acc_last  = we_l ? WRITE_LAST : SENSE_LAST;
  assign acc_end   = (cnt == acc_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (grant_any) begin
          cnt_nx   = '0;
          state_nx = addr_bad ? DONE : PRECH;
        end
      end
      PRECH: begin
        if (cnt == PRE_LAST) begin
          cnt_nx   = '0;
          state_nx = ACCESS;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      ACCESS: begin
        if (acc_end) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant-time latching, starve tracking and read capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_s      <= 1'b0;
      we_l       <= 1'b0;
      err_l      <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      dout_q     <= '0;
      rdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        own_s <= grant_s;
        we_l  <= grant_s || bus.p_we;
        err_l <= addr_bad;
        // A rejected request leaves the macro-facing outputs untouched.
        if (!addr_bad) begin
          addr_q <= win_addr;
          sel_q  <= grant_s ? bus.s_sel : bus.p_sel;
          if (grant_s)       dout_q <= bus.s_wdata;
          else if (bus.p_we) dout_q <= bus.p_wdata;
          else               dout_q <= '0;
        end
        if (grant_s)
          starve_cnt <= '0;
        else if (s_elig && starve_cnt != STARVE_MAX)
          starve_cnt <= starve_cnt + 4'd1;
      end
      if (state == ACCESS && !we_l && !own_s && cnt == SENSE_LAST)
        rdata_q <= bus.mem_read_in;
    end
  end

  // Strobes decode straight from state so reset drops them at once.
  assign bus.PC_B         = (state != PRECH);
  assign bus.WE           = (state == ACCESS) && we_l;
  assign bus.SE           = (state == ACCESS) && !we_l;
  assign bus.busy         = (state != IDLE);
  assign bus.p_ack        = (state == DONE) && !own_s;
  assign bus.p_err        = (state == DONE) && !own_s && err_l;
  assign bus.s_ack        = (state == DONE) && own_s;
  assign bus.s_err        = (state == DONE) && own_s && err_l;
  assign bus.p_rdata      = rdata_q;
  assign bus.mem_address  = addr_q;
  assign bus.mem_sel      = sel_q;
  assign bus.mem_data_out = dout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one access from cycle 1 to its ack cycle, checking the strobe
  // pattern {PC_B,WE,SE,p_ack,s_ack,err} each cycle for defaults 2/2/4.
  // The request is dropped in the ack cycle.
  task automatic run_seq(input string tag, input bit wr, input bit sens, input bit rej);
    int last;
    logic pc, ph, ak;
    last = rej ? 1 : (2 + (wr ? 4 : 2) + 1);
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      pc = !(!rej && n >= 1 && n <= 2);
      ph = !rej && n >= 3 && n < last;
      ak = (n == last);
      check(tag,
            {26'd0, bus.PC_B, bus.WE, bus.SE, bus.p_ack, bus.s_ack, bus.p_err | bus.s_err},
            {26'd0, pc, wr & ph, !wr & ph, ak & !sens, ak & sens, ak & rej});
      if (ak) begin
        if (sens) bus.s_req = 1'b0;
        else      bus.p_req = 1'b0;
      end
    end
  endtask

  initial begin
    logic [1:0] got;
    logic [1:0] order [8];
    bit         quiet;

    bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_sel = 0; bus.p_wdata = 0;
    bus.s_req = 0; bus.s_addr = 0; bus.s_sel = 0; bus.s_wdata = 0;
    bus.tx_enable = 0; bus.mem_read_in = 0;

    repeat (3) @(negedge clk);
    check("reset_strobes", {28'd0, bus.PC_B, bus.WE, bus.SE, bus.busy}, 32'h8);
    check("reset_outs", {bus.p_ack, bus.p_err, bus.s_ack, bus.s_err, bus.mem_address, bus.mem_sel},
          32'h0);
    check("reset_data", {bus.p_rdata, bus.mem_data_out}, 32'h0);
    reset = 1'b1;

    // Protocol read, addr 5
    @(negedge clk);
    bus.p_req = 1; bus.p_we = 0; bus.p_addr = 6'd5; bus.p_sel = 3'd3;
    bus.mem_read_in = 16'hA5C3;
    run_seq("p_read", 0, 0, 0);
    @(negedge clk);
    check("p_read_rdata", bus.p_rdata, 32'hA5C3);
    check("p_read_addr", {bus.mem_sel, bus.mem_address}, {3'd3, 6'd5});
    check("p_read_dout", bus.mem_data_out, 32'h0);

    // Sensor write, addr 10
    bus.s_req = 1; bus.s_addr = 6'd10; bus.s_sel = 3'd1; bus.s_wdata = 16'h1234;
    run_seq("s_write", 1, 1, 0);
    @(negedge clk);
    check("s_write_addr", bus.mem_address, 32'd10);
    check("s_write_dout", bus.mem_data_out, 32'h1234);
    check("s_write_rdata", bus.p_rdata, 32'hA5C3);

    // Contention: both held high, expected order P,P,P,S,P,P,P,S
    order = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    bus.mem_read_in = 16'h0F0F;
    bus.p_req = 1; bus.p_we = 0; bus.p_addr = 6'd1;
    bus.s_req = 1; bus.s_addr = 6'd2;
    for (int g = 0; g < 8; g++) begin
      got = 2'b00;
      for (int t = 0; t < 20 && got == 2'b00; t++) begin
        @(negedge clk);
        got = {bus.p_ack, bus.s_ack};
      end
      check($sformatf("grant_%0d", g), {30'd0, got}, {30'd0, order[g]});
    end
    bus.p_req = 0; bus.s_req = 0;
    @(negedge clk);
    check("contend_rdata", bus.p_rdata, 32'h0F0F);

    // tx_enable blocks the sensor
    bus.tx_enable = 1; bus.s_req = 1; bus.s_addr = 6'd10; bus.s_wdata = 16'h4321;
    quiet = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!bus.PC_B || bus.busy || bus.s_ack) quiet = 0;
    end
    check("tx_block", {31'd0, quiet}, 32'd1);
    bus.tx_enable = 0;
    run_seq("tx_release", 1, 1, 0);
    @(negedge clk);
    check("tx_release_dout", bus.mem_data_out, 32'h4321);

    // Rejected address
    bus.p_req = 1; bus.p_we = 0; bus.p_addr = 6'd50;
    run_seq("reject", 0, 0, 1);
    @(negedge clk);
    check("reject_rdata", bus.p_rdata, 32'h0F0F);
    check("reject_addr", bus.mem_address, 32'd10);
    check("reject_idle", {31'd0, bus.busy}, 32'd0);

    // Reset mid-write
    bus.s_req = 1; bus.s_addr = 6'd7; bus.s_sel = 3'd2; bus.s_wdata = 16'hBEEF;
    repeat (4) @(negedge clk);
    check("pre_reset_we", {30'd0, bus.WE, bus.PC_B}, 32'h3);
    reset = 1'b0;
    #1;
    check("reset_mid", {28'd0, bus.WE, bus.PC_B, bus.s_ack, bus.busy}, 32'h4);
    quiet = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.s_ack || bus.WE) quiet = 0;
    end
    check("reset_no_ack", {31'd0, quiet}, 32'd1);
    reset = 1'b1;
    run_seq("rewrite", 1, 1, 0);
    @(negedge clk);
    check("rewrite_data", {bus.mem_sel, bus.mem_address, bus.mem_data_out}, {3'd2, 6'd7, 16'hBEEF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
